// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_LEN0 = 3'd1;
    localparam state_t S_LEN1 = 3'd2;
    localparam state_t S_DATA = 3'd3;
    localparam state_t S_CSUM = 3'd4;
    localparam state_t S_DONE = 3'd5;
    localparam state_t S_ERR  = 3'd6;

    // True while a load is in progress (length, payload or checksum phase).
    function automatic logic is_busy(input state_t s);
        return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: first byte of a group lands in bits 7:0.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic        last_o,
    output logic [31:0] word_o,
    output logic        we_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;
    logic [31:0] word_q, word_d;
    logic        we_q, we_d;

    assign last_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o = word_q;
    assign we_o   = we_q;

    // Shift bytes in from the top; the fourth byte completes the word directly.
    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        word_d = word_q;
        we_d   = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {byte_i, sr_q[23:8]};
            if (last_o) begin
                word_d = {byte_i, sr_q};
                we_d   = 1'b1;
            end
        end
    end

    // Packer state registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            word_q <= '0;
            we_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            word_q <= word_d;
            we_q   <= we_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: length header, little-endian words, XOR checksum.
// ADDR_W is expected to be at most 16 (word count is a 16-bit field).
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic        accept;
    logic        start_ok;
    logic        pk_en;
    logic        pk_last;
    logic        word_done;
    logic [15:0] n_full;

    assign busy     = is_busy(state_q);
    assign rx_ready = busy;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign core_rst = (state_q != S_DONE);
    assign im_addr  = addr_q;

    assign accept    = rx_valid && rx_ready;
    assign start_ok  = start && !busy;
    assign pk_en     = accept && (state_q == S_DATA);
    assign word_done = pk_en && pk_last;
    assign n_full    = {rx_data, len_q[7:0]};

    byte_packer u_packer (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr_i  (start_ok),
        .en_i   (pk_en),
        .byte_i (rx_data),
        .last_o (pk_last),
        .word_o (im_wdata),
        .we_o   (im_we)
    );

    // Next-state logic for the load sequence and its counters.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN0;
                    len_d   = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    if (n_full == '0)
                        state_d = S_CSUM;
                    else if ({1'b0, n_full} > CAPACITY)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    if (word_done) begin
                        addr_d = idx_q[ADDR_W-1:0];
                        idx_d  = idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1)
                            state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept)
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Loader state registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are sent.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_we   = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  csum;
    int unsigned widx;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (im_we === 1'b1) begin
            n_we++;
            if (exp_q.size() == 0)
                check("we_unexpected", 64'(im_we), 64'h0);
            else
                check("we_word", {32'(im_addr), im_wdata}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok = 0;
        bit r;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            r = rx_ready;
            tick();
            if (r) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("rx_timeout", 64'd0, 64'd1);
        if (gap) begin
            rx_valid = 1'b0;
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            if (k == 3) begin
                exp_q.push_back({32'(widx), w});
                widx++;
            end
            csum = csum ^ b;
            send_byte(b, gap);
        end
    endtask

    task automatic begin_load(input logic [15:0] n);
        csum = 8'h00;
        widx = 0;
        do_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_core_rst", 64'(core_rst), 64'd1);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
    endtask

    task automatic settle(input string tag);
        rx_valid = 1'b0;
        repeat (3) tick();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e);
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_err"}, 64'(err), 64'(e));
        check({tag, "_core_rst"}, 64'(core_rst), 64'(!d));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned we_before;
        logic [31:0] w;

        RST = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_im_we", 64'(im_we), 64'd0);
        check("rst_im_addr", 64'(im_addr), 64'd0);
        check("rst_im_wdata", 64'(im_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_core_rst", 64'(core_rst), 64'd1);
        tick();
        RST = 1'b0;
        tick();

        // Two-word load with correct checksum.
        begin_load(16'd2);
        send_word(32'h0050_0093, 0);
        send_word(32'h0070_0113, 0);
        check("csum_model", 64'(csum), 64'hA1);
        send_byte(8'hA1, 0);
        check_status("good", 1'b1, 1'b0);
        settle("good_pending");
        check("done_hold", 64'(done), 64'd1);

        // Restart from DONE; same stream, wrong checksum.
        begin_load(16'd2);
        send_word(32'h0050_0093, 0);
        send_word(32'h0070_0113, 0);
        send_byte(8'hA0, 0);
        check_status("badcsum", 1'b0, 1'b1);
        settle("badcsum_pending");
        check("err_hold", 64'(err), 64'd1);

        // Oversize length: N = 257 with 256-word memory.
        we_before = n_we;
        begin_load(16'h0101);
        check_status("oversize", 1'b0, 1'b1);
        settle("oversize_pending");
        check("oversize_no_we", 64'(n_we), 64'(we_before));

        // Empty load.
        begin_load(16'd0);
        send_byte(8'h00, 0);
        check_status("empty", 1'b1, 1'b0);

        // One word with rx_valid gaps between bytes.
        we_before = n_we;
        begin_load(16'd1);
        send_word(32'h0050_0093, 1);
        send_byte(csum, 1);
        check_status("gapped", 1'b1, 1'b0);
        settle("gapped_pending");
        check("gapped_one_we", 64'(n_we), 64'(we_before + 1));

        // Start pulse in the middle of DATA must be ignored.
        begin_load(16'd2);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        do_start();
        check("start_ignored", 64'(busy), 64'd1);
        csum = 8'h93;
        w = 32'h0050_0093;
        exp_q.push_back({32'(widx), w}); widx++;
        csum = csum ^ 8'h50;
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        send_word(32'h0070_0113, 0);
        send_byte(csum, 0);
        check_status("midstart", 1'b1, 1'b0);
        settle("midstart_pending");

        // Reset in the middle of DATA aborts without further writes.
        begin_load(16'd2);
        send_word(32'h0050_0093, 0);
        send_byte(8'h13, 0);
        send_byte(8'h01, 0);
        #2 RST = 1'b1;
        #1;
        check("midrst_im_we", 64'(im_we), 64'd0);
        check("midrst_core_rst", 64'(core_rst), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rx_ready", 64'(rx_ready), 64'd0);
        check("midrst_done_err", 64'({done, err}), 64'd0);
        we_before = n_we;
        rx_valid = 1'b0;
        tick();
        RST = 1'b0;
        settle("midrst_pending");
        check("midrst_no_we", 64'(n_we), 64'(we_before));

        // Full-capacity load: last write lands at address 2^ADDR_W-1.
        begin_load(16'd256);
        for (int i = 0; i < 256; i++) send_word($urandom, 0);
        send_byte(csum, 0);
        check_status("full", 1'b1, 1'b0);
        settle("full_pending");
        check("full_last_addr", 64'(im_addr), 64'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
